mem_port_arbiter: RTL and testbench

- Shares the single-ported unified instruction/data memory between two requesters: port 0 (multicycle core fetch/load/store) and port 1 (debug/program loader).
- Sits between the requesters and the memory macro.
- Allows one transaction in flight at a time. Each accepted request gets exactly one completion pulse.
- Stalls the losing requester until its request is granted.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_pick.sv | 38 +++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter.
// Optional round-robin arbitration is enabled by defining MEM_PORT_ARBITER_RR_EN.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_DBG  = 1'b1
    } port_t;

    localparam int unsigned NUM_PORTS = 2;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner select for the two memory requesters.
// MEM_PORT_ARBITER_RR_EN selects round-robin on ties; otherwise port 1 has fixed priority.
module mem_port_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic                 req0,
    input  logic                 req1,
    input  port_t                last_win,
    output logic [NUM_PORTS-1:0] gnt_vec,
    output port_t                winner
);

`ifndef MEM_PORT_ARBITER_RR_EN
    logic unused_last_win;
    assign unused_last_win = last_win;
`endif

    always_comb begin
        gnt_vec = '0;
        winner  = PORT_CORE;
`ifdef MEM_PORT_ARBITER_RR_EN
        // On a tie the port that did not win last time goes first.
        if (req0 && req1) begin
            winner = (last_win == PORT_DBG) ? PORT_CORE : PORT_DBG;
        end else if (req1) begin
            winner = PORT_DBG;
        end
`else
        if (req1) begin
            winner = PORT_DBG;
        end
`endif
        if (req0 || req1) begin
            gnt_vec[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-ported memory; one transaction in flight at a time.
// Define MEM_PORT_ARBITER_RR_EN for round-robin tie breaking (default: port 1 wins ties).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              resp0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              resp1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_wen,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    if (READ_LATENCY < 1) begin : g_lat_chk
        $error("mem_port_arbiter: READ_LATENCY must be at least 1");
    end

    state_t                state;
    state_t                state_nx;
    port_t                 owner_q;
    logic                  we_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W-1:0]     rdata_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [NUM_PORTS-1:0]  pick_gnt;
    port_t                 pick_win;
    port_t                 rr_ptr;
    logic                  grant;

    mem_port_pick u_pick (
        .req0     (req0),
        .req1     (req1),
        .last_win (rr_ptr),
        .gnt_vec  (pick_gnt),
        .winner   (pick_win)
    );

    assign grant = (state == IDLE) && (|pick_gnt);

`ifdef MEM_PORT_ARBITER_RR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= PORT_CORE;
        end else if (grant) begin
            rr_ptr <= pick_win;
        end
    end
`else
    assign rr_ptr = PORT_CORE;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|pick_gnt) state_nx = ACCESS;
            ACCESS:  state_nx = we_q ? RESP : WAIT;
            WAIT:    if (cnt_q == '0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= PORT_CORE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (grant) begin
                owner_q <= pick_win;
                we_q    <= (pick_win == PORT_DBG) ? we1    : we0;
                addr_q  <= (pick_win == PORT_DBG) ? addr1  : addr0;
                wdata_q <= (pick_win == PORT_DBG) ? wdata1 : wdata0;
            end
            if (state == ACCESS && !we_q) begin
                cnt_q <= CNT_W'(READ_LATENCY - 1);
            end
            // Counter parks at zero on the capture cycle rather than wrapping.
            if (state == WAIT) begin
                if (cnt_q == '0) begin
                    rdata_q <= mem_rdata;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        resp0   = 1'b0;
        resp1   = 1'b0;
        mem_wen = 1'b0;
        mem_ren = 1'b0;
        if (state == IDLE) begin
            gnt0 = pick_gnt[PORT_CORE];
            gnt1 = pick_gnt[PORT_DBG];
        end
        if (state == ACCESS) begin
            mem_wen = we_q;
            mem_ren = !we_q;
        end
        if (state == RESP) begin
            resp0 = (owner_q == PORT_CORE);
            resp1 = (owner_q == PORT_DBG);
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: READ_LATENCY=1 instance with a response scoreboard,
// plus a READ_LATENCY=3 instance for capture timing.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          port;
        bit          is_read;
        logic [31:0] data;
    } sb_t;
    sb_t sb_q[$];
    sb_t mon_e;
    bit  last_win = 1'b0;

    // DUT A: READ_LATENCY = 1
    logic        a_req0 = 0, a_we0 = 0, a_req1 = 0, a_we1 = 0;
    logic [15:0] a_addr0 = '0, a_addr1 = '0;
    logic [31:0] a_wdata0 = '0, a_wdata1 = '0;
    logic        a_gnt0, a_gnt1, a_resp0, a_resp1, a_mem_wen, a_mem_ren;
    logic [31:0] a_rdata, a_mem_wdata, a_mem_rdata;
    logic [15:0] a_mem_addr;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .READ_LATENCY(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .req0(a_req0), .we0(a_we0), .addr0(a_addr0), .wdata0(a_wdata0), .gnt0(a_gnt0), .resp0(a_resp0),
        .req1(a_req1), .we1(a_we1), .addr1(a_addr1), .wdata1(a_wdata1), .gnt1(a_gnt1), .resp1(a_resp1),
        .rdata(a_rdata), .mem_wen(a_mem_wen), .mem_ren(a_mem_ren), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    // Memory A: one-cycle read pipe; garbage when no read strobe so a mistimed capture shows.
    logic [31:0] mem_a [0:255];
    always @(posedge clk) begin
        if (!rst) begin
            mem_a[8'h10] <= 32'hDEADBEEF;
            a_mem_rdata  <= 32'h0;
        end else begin
            if (a_mem_wen) mem_a[a_mem_addr[7:0]] <= a_mem_wdata;
            a_mem_rdata <= a_mem_ren ? mem_a[a_mem_addr[7:0]] : {16'hBAD0, cyc[15:0]};
        end
    end

    // DUT B: READ_LATENCY = 3
    logic        b_req0 = 0, b_we0 = 0, b_req1 = 0, b_we1 = 0;
    logic [15:0] b_addr0 = '0, b_addr1 = '0;
    logic [31:0] b_wdata0 = '0, b_wdata1 = '0;
    logic        b_gnt0, b_gnt1, b_resp0, b_resp1, b_mem_wen, b_mem_ren;
    logic [31:0] b_rdata, b_mem_wdata, b_mem_rdata;
    logic [15:0] b_mem_addr;
    logic [31:0] b_p0, b_p1;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .READ_LATENCY(3)) u_dut_b (
        .clk(clk), .rst(rst),
        .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0), .gnt0(b_gnt0), .resp0(b_resp0),
        .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1), .gnt1(b_gnt1), .resp1(b_resp1),
        .rdata(b_rdata), .mem_wen(b_mem_wen), .mem_ren(b_mem_ren), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    always @(posedge clk) begin
        b_p0        <= b_mem_ren ? ((b_mem_addr == 16'h0030) ? 32'hCAFEF00D : 32'h0) : {16'hBAD1, cyc[15:0]};
        b_p1        <= b_p0;
        b_mem_rdata <= b_p1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input bit port, input bit is_read, input logic [31:0] data);
        sb_t e;
        e.port    = port;
        e.is_read = is_read;
        e.data    = data;
        sb_q.push_back(e);
    endtask

    function automatic bit model_pick(input bit r0, input bit r1);
`ifdef MEM_PORT_ARBITER_RR_EN
        if (r0 && r1) return !last_win;
`endif
        return r1;
    endfunction

    // Scoreboard consumer for DUT A completions
    always @(negedge clk) begin
        if (rst && (a_resp0 || a_resp1)) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_resp", {a_resp1, a_resp0}, 64'h0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_port", {a_resp1, a_resp0}, mon_e.port ? 64'h2 : 64'h1);
                if (mon_e.is_read) chk("sb_rdata", a_rdata, mon_e.data);
            end
        end
    end

    initial begin
        // Reset asserted mid-cycle, before any clock edge.
        #3 rst = 1'b0;
        #1;
        chk("rst_ctl", {a_gnt0, a_gnt1, a_resp0, a_resp1, a_mem_wen, a_mem_ren}, 64'h0);
        chk("rst_rdata", a_rdata, 64'h0);
        chk("rst_addr", a_mem_addr, 64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk("idle_quiet", {a_gnt0, a_gnt1, a_resp0, a_resp1, a_mem_wen, a_mem_ren}, 64'h0);
        end

        // Port 0 read of 0x0010
        @(negedge clk); a_req0 = 1; a_we0 = 0; a_addr0 = 16'h0010; #1;
        chk("rd0_gnt", {a_gnt1, a_gnt0}, 64'h1);
        sb_push(0, 1, 32'hDEADBEEF); last_win = 0;
        @(negedge clk); a_req0 = 0; #1;
        chk("rd0_access", {a_mem_wen, a_mem_ren, a_mem_addr}, {46'h0, 1'b0, 1'b1, 16'h0010});
        @(negedge clk); #1;
        chk("rd0_no_early_resp", {a_resp1, a_resp0}, 64'h0);
        @(negedge clk); #1;
        chk("rd0_resp", {a_resp1, a_resp0}, 64'h1);
        chk("rd0_rdata", a_rdata, 64'hDEADBEEF);

        // Port 1 write 0x12345678 to 0x0020, then port 0 reads it back
        @(negedge clk); a_req1 = 1; a_we1 = 1; a_addr1 = 16'h0020; a_wdata1 = 32'h12345678; #1;
        chk("wr1_gnt", {a_gnt1, a_gnt0}, 64'h2);
        sb_push(1, 0, 32'h0); last_win = 1;
        @(negedge clk); a_req1 = 0; #1;
        chk("wr1_access", {a_mem_wen, a_mem_ren, a_mem_addr, a_mem_wdata},
            {14'h0, 1'b1, 1'b0, 16'h0020, 32'h12345678});
        @(negedge clk); #1;
        chk("wr1_resp", {a_resp1, a_resp0, a_mem_wen}, 64'h4);
        chk("wr1_rdata_kept", a_rdata, 64'hDEADBEEF);
        @(negedge clk); a_req0 = 1; a_we0 = 0; a_addr0 = 16'h0020; #1;
        chk("rb0_gnt", {a_gnt1, a_gnt0}, 64'h1);
        sb_push(0, 1, 32'h12345678); last_win = 0;
        @(negedge clk); a_req0 = 0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("rb0_resp", {a_resp1, a_resp0}, 64'h1);

        // Both ports request reads continuously for four transactions
        @(negedge clk);
        a_req0 = 1; a_we0 = 0; a_addr0 = 16'h0010;
        a_req1 = 1; a_we1 = 0; a_addr1 = 16'h0020;
        #1;
        for (int t = 0; t < 4; t++) begin
            bit w;
            w = model_pick(1, 1);
            chk("tie_gnt", {a_gnt1, a_gnt0}, w ? 64'h2 : 64'h1);
            sb_push(w, 1, w ? 32'h12345678 : 32'hDEADBEEF);
            last_win = w;
            @(negedge clk); #1;
            chk("busy_no_gnt", {a_gnt1, a_gnt0}, 64'h0);
            repeat (3) @(negedge clk);
            #1;
        end
        // Port 1 withdraws in IDLE; port 0 is granted here.
        a_req1 = 0; #1;
        chk("tail_gnt0", {a_gnt1, a_gnt0}, 64'h1);
        sb_push(0, 1, 32'hDEADBEEF); last_win = 0;
        @(negedge clk); a_req0 = 0;
        @(negedge clk);
        @(negedge clk);

        // READ_LATENCY=3 instance
        @(negedge clk); b_req0 = 1; b_we0 = 0; b_addr0 = 16'h0030; #1;
        chk("rl3_gnt", {b_gnt1, b_gnt0}, 64'h1);
        @(negedge clk); b_req0 = 0; #1;
        chk("rl3_access", {b_mem_ren, b_mem_addr}, {47'h0, 1'b1, 16'h0030});
        @(negedge clk);
        @(negedge clk);
        @(negedge clk); #1;
        chk("rl3_no_early_resp", {b_resp1, b_resp0}, 64'h0);
        @(negedge clk); #1;
        chk("rl3_resp", {b_resp1, b_resp0}, 64'h1);
        chk("rl3_rdata", b_rdata, 64'hCAFEF00D);

        // Reset while DUT A sits in WAIT: no completion may follow
        @(negedge clk); a_req0 = 1; a_we0 = 0; a_addr0 = 16'h0010; #1;
        chk("rw_gnt", {a_gnt1, a_gnt0}, 64'h1);
        @(negedge clk); a_req0 = 0;
        @(negedge clk); #3;
        rst = 1'b0; #1;
        chk("rw_rst_ctl", {a_gnt0, a_gnt1, a_resp0, a_resp1, a_mem_wen, a_mem_ren}, 64'h0);
        chk("rw_rst_rdata", a_rdata, 64'h0);
        last_win = 0;
        @(negedge clk); rst = 1'b1; #1;
        chk("rw_no_resp_a", {a_resp1, a_resp0}, 64'h0);
        @(negedge clk); #1;
        chk("rw_no_resp_b", {a_resp1, a_resp0}, 64'h0);
        @(negedge clk); a_req0 = 1; a_we0 = 0; a_addr0 = 16'h0020; #1;
        chk("rw_fresh_gnt", {a_gnt1, a_gnt0}, 64'h1);
        sb_push(0, 1, 32'h12345678); last_win = 0;
        @(negedge clk); a_req0 = 0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("rw_fresh_resp", {a_resp1, a_resp0}, 64'h1);
        @(negedge clk); #1;
        chk("sb_drained", sb_q.size(), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
